// File: rtl/ab_arb_pkg.sv
// Shared types for the A/B policy recovery arbiter: FSM states, grant encodings, default widths.
package ab_arb_pkg;

  localparam int unsigned RefWDefault = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeA = 2'd1,
    StServeB = 2'd2
  } arb_state_e;

  localparam logic [1:0] GrantNone = 2'b00;
  localparam logic [1:0] GrantA    = 2'b01;
  localparam logic [1:0] GrantB    = 2'b10;

  function automatic logic [1:0] grant_of(arb_state_e st);
    case (st)
      StServeA: grant_of = GrantA;
      StServeB: grant_of = GrantB;
      default:  grant_of = GrantNone;
    endcase
  endfunction

endpackage

// File: rtl/ab_policy_recovery_arbiter_if.sv
// Plant, enforcer, arbitrated-output and violation-log signals of the A/B policy arbiter.
interface ab_policy_recovery_arbiter_if import ab_arb_pkg::*; #(
  parameter int unsigned REF_W = RefWDefault,
  parameter int unsigned CNT_W = 8
);
  logic             A_ctp_in;
  logic             B_ctp_in;
  logic             policy_a_A_ctp;
  logic             policy_a_B_ctp;
  logic             policy_b_A_ctp;
  logic             policy_b_B_ctp;
  logic [REF_W-1:0] policy_a_recovery_ref;
  logic [REF_W-1:0] policy_b_recovery_ref;
  logic             A_ctp_out;
  logic             B_ctp_out;
  logic [1:0]       grant;
  logic             conflict;
  logic [CNT_W-1:0] viol_count_a;
  logic [CNT_W-1:0] viol_count_b;
  logic             log_valid;
  logic             log_ready;
  logic             log_policy;
  logic [REF_W-1:0] log_ref;

  modport slave (
    input  A_ctp_in, B_ctp_in, policy_a_A_ctp, policy_a_B_ctp, policy_b_A_ctp, policy_b_B_ctp,
    input  policy_a_recovery_ref, policy_b_recovery_ref, log_ready,
    output A_ctp_out, B_ctp_out, grant, conflict, viol_count_a, viol_count_b,
    output log_valid, log_policy, log_ref
  );

  modport master (
    output A_ctp_in, B_ctp_in, policy_a_A_ctp, policy_a_B_ctp, policy_b_A_ctp, policy_b_B_ctp,
    output policy_a_recovery_ref, policy_b_recovery_ref, log_ready,
    input  A_ctp_out, B_ctp_out, grant, conflict, viol_count_a, viol_count_b,
    input  log_valid, log_policy, log_ref
  );

endinterface

// File: rtl/ab_arb_log_buffer.sv
// Single-entry violation log: holds {policy, ref} until the consumer takes it.
module ab_arb_log_buffer #(
  parameter int unsigned RefW = 3
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            push_i,
  input  logic            push_policy_i,
  input  logic [RefW-1:0] push_ref_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic            policy_o,
  output logic [RefW-1:0] ref_o
);

  logic            valid_q, valid_d;
  logic            policy_q, policy_d;
  logic [RefW-1:0] ref_q, ref_d;

  // A push is accepted only into an empty slot or one being drained this cycle.
  always_comb begin
    valid_d  = valid_q;
    policy_d = policy_q;
    ref_d    = ref_q;
    if (push_i && (!valid_q || ready_i)) begin
      valid_d  = 1'b1;
      policy_d = push_policy_i;
      ref_d    = push_ref_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q  <= 1'b0;
      policy_q <= 1'b0;
      ref_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      policy_q <= policy_d;
      ref_q    <= ref_d;
    end
  end

  assign valid_o  = valid_q;
  assign policy_o = policy_q;
  assign ref_o    = ref_q;

endmodule

// File: rtl/ab_policy_recovery_arbiter.sv
// Arbitrates two policy enforcers' edits onto the plant with sticky, starvation-bounded grants.
// Optional violation log buffer is built when AB_ARB_LOG_EN is defined.
module ab_policy_recovery_arbiter import ab_arb_pkg::*; #(
  parameter int unsigned REF_W    = RefWDefault,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HOLD_MAX = 4
) (
  input logic                         clk,
  input logic                         reset,
  ab_policy_recovery_arbiter_if.slave bus
);

  localparam int unsigned HoldW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             req_a, req_b, conflict_now, hold_expired;
  arb_state_e       state_q, state_d;
  logic             rr_q, rr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             a_out_q, a_out_d, b_out_q, b_out_d, conflict_q;
  logic [1:0]       grant_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  assign req_a        = bus.policy_a_recovery_ref != '0;
  assign req_b        = bus.policy_b_recovery_ref != '0;
  assign conflict_now = req_a && req_b &&
      ({bus.policy_a_A_ctp, bus.policy_a_B_ctp} != {bus.policy_b_A_ctp, bus.policy_b_B_ctp});
  assign hold_expired = conflict_now && (hold_q >= HoldW'(HOLD_MAX));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      StIdle: begin
        if (req_a && req_b) begin
          state_d = rr_q ? StServeB : StServeA;
          rr_d    = ~rr_q;
        end else if (req_a) begin
          state_d = StServeA;
        end else if (req_b) begin
          state_d = StServeB;
        end
      end
      StServeA: begin
        if (req_a) begin
          if (hold_expired) state_d = StServeB;
        end else begin
          state_d = req_b ? StServeB : StIdle;
        end
      end
      StServeB: begin
        if (req_b) begin
          if (hold_expired) state_d = StServeA;
        end else begin
          state_d = req_a ? StServeA : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Starvation counter only runs while a grant is held against a live conflict.
    hold_d = ((state_d == state_q) && (state_q != StIdle) && conflict_now) ?
             hold_q + 1'b1 : '0;

    a_out_d = bus.A_ctp_in;
    b_out_d = bus.B_ctp_in;
    case (state_d)
      StServeA: begin
        a_out_d = bus.policy_a_A_ctp;
        b_out_d = bus.policy_a_B_ctp;
      end
      StServeB: begin
        a_out_d = bus.policy_b_A_ctp;
        b_out_d = bus.policy_b_B_ctp;
      end
      default: ;
    endcase

    cnt_a_d = (req_a && (cnt_a_q != CntMax)) ? cnt_a_q + 1'b1 : cnt_a_q;
    cnt_b_d = (req_b && (cnt_b_q != CntMax)) ? cnt_b_q + 1'b1 : cnt_b_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      hold_q     <= '0;
      a_out_q    <= 1'b0;
      b_out_q    <= 1'b0;
      grant_q    <= GrantNone;
      conflict_q <= 1'b0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      hold_q     <= hold_d;
      a_out_q    <= a_out_d;
      b_out_q    <= b_out_d;
      grant_q    <= grant_of(state_d);
      conflict_q <= conflict_now;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
    end
  end

  assign bus.A_ctp_out    = a_out_q;
  assign bus.B_ctp_out    = b_out_q;
  assign bus.grant        = grant_q;
  assign bus.conflict     = conflict_q;
  assign bus.viol_count_a = cnt_a_q;
  assign bus.viol_count_b = cnt_b_q;

`ifdef AB_ARB_LOG_EN
  logic             log_push, log_pol;
  logic [REF_W-1:0] log_ref_in;

  // A log event is any entry into a serve state, including forced switches.
  assign log_push   = (state_d != state_q) && (state_d != StIdle);
  assign log_pol    = (state_d == StServeB);
  assign log_ref_in = log_pol ? bus.policy_b_recovery_ref : bus.policy_a_recovery_ref;

  ab_arb_log_buffer #(
    .RefW (REF_W)
  ) u_log_buffer (
    .clk_i         (clk),
    .reset_i       (reset),
    .push_i        (log_push),
    .push_policy_i (log_pol),
    .push_ref_i    (log_ref_in),
    .ready_i       (bus.log_ready),
    .valid_o       (bus.log_valid),
    .policy_o      (bus.log_policy),
    .ref_o         (bus.log_ref)
  );
`else
  logic unused_log_ready;
  assign unused_log_ready = bus.log_ready;
  assign bus.log_valid    = 1'b0;
  assign bus.log_policy   = 1'b0;
  assign bus.log_ref      = '0;
`endif

endmodule

// File: tb/tb_ab_policy_recovery_arbiter.sv
// Directed self-checking bench for ab_policy_recovery_arbiter (default and AB_ARB_LOG_EN builds).
module tb_ab_policy_recovery_arbiter;
  import ab_arb_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ab_policy_recovery_arbiter_if #(.REF_W(3), .CNT_W(8)) bus ();

  ab_policy_recovery_arbiter #(
    .REF_W    (3),
    .CNT_W    (8),
    .HOLD_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ea/eb are {A_ctp, B_ctp} edits of policy a / b.
  task automatic drive(input logic [2:0] ra, input logic [2:0] rb, input logic [1:0] ea,
                       input logic [1:0] eb, input logic ain, input logic bin);
    bus.policy_a_recovery_ref = ra;
    bus.policy_b_recovery_ref = rb;
    bus.policy_a_A_ctp        = ea[1];
    bus.policy_a_B_ctp        = ea[0];
    bus.policy_b_A_ctp        = eb[1];
    bus.policy_b_B_ctp        = eb[0];
    bus.A_ctp_in              = ain;
    bus.B_ctp_in              = bin;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.log_ready = 1'b1;
    drive(3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    checks++;
    if (bus.grant !== 2'b00) begin
      failures++; $display("FAIL reset_grant: got %b expected 00", bus.grant);
    end
    checks++;
    if ({bus.A_ctp_out, bus.B_ctp_out, bus.conflict} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outs: got %b expected 000", {bus.A_ctp_out, bus.B_ctp_out, bus.conflict});
    end
    checks++;
    if ({bus.viol_count_a, bus.viol_count_b} !== 16'h0) begin
      failures++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", bus.viol_count_a, bus.viol_count_b);
    end
    checks++;
    if ({bus.log_valid, bus.log_policy, bus.log_ref} !== 5'b0) begin
      failures++;
      $display("FAIL reset_log: got %b expected 00000", {bus.log_valid, bus.log_policy, bus.log_ref});
    end
  endtask

  task automatic test_single_a();
    drive(3'd3, 3'd0, 2'b01, 2'b00, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.grant !== 2'b01) begin
      failures++; $display("FAIL single_grant: got %b expected 01", bus.grant);
    end
    checks++;
    if ({bus.A_ctp_out, bus.B_ctp_out} !== 2'b01) begin
      failures++; $display("FAIL single_outs: got %b expected 01", {bus.A_ctp_out, bus.B_ctp_out});
    end
    checks++;
    if (bus.viol_count_a !== 8'd1) begin
      failures++; $display("FAIL single_viol_a: got %0d expected 1", bus.viol_count_a);
    end
`ifdef AB_ARB_LOG_EN
    checks++;
    if ({bus.log_valid, bus.log_policy, bus.log_ref} !== 5'b1_0_011) begin
      failures++;
      $display("FAIL single_log: got %b expected 10011", {bus.log_valid, bus.log_policy, bus.log_ref});
    end
`endif
    drive(3'd0, 3'd0, 2'b01, 2'b00, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.grant !== 2'b00) begin
      failures++; $display("FAIL single_release_grant: got %b expected 00", bus.grant);
    end
    checks++;
    if ({bus.A_ctp_out, bus.B_ctp_out} !== 2'b11) begin
      failures++;
      $display("FAIL single_passthru: got %b expected 11", {bus.A_ctp_out, bus.B_ctp_out});
    end
    checks++;
    if (bus.log_valid !== 1'b0) begin
      failures++; $display("FAIL single_log_drain: got %b expected 0", bus.log_valid);
    end
  endtask

  task automatic test_round_robin();
    drive(3'd1, 3'd2, 2'b10, 2'b01, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.grant, bus.conflict} !== 3'b01_1) begin
      failures++; $display("FAIL rr_first: got %b expected 011", {bus.grant, bus.conflict});
    end
    checks++;
    if ({bus.A_ctp_out, bus.B_ctp_out} !== 2'b10) begin
      failures++; $display("FAIL rr_first_outs: got %b expected 10", {bus.A_ctp_out, bus.B_ctp_out});
    end
    drive(3'd0, 3'd0, 2'b10, 2'b01, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.grant, bus.conflict} !== 3'b00_0) begin
      failures++; $display("FAIL rr_idle: got %b expected 000", {bus.grant, bus.conflict});
    end
    drive(3'd1, 3'd2, 2'b10, 2'b01, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.grant, bus.conflict} !== 3'b10_1) begin
      failures++; $display("FAIL rr_second: got %b expected 101", {bus.grant, bus.conflict});
    end
    checks++;
    if ({bus.A_ctp_out, bus.B_ctp_out} !== 2'b01) begin
      failures++; $display("FAIL rr_second_outs: got %b expected 01", {bus.A_ctp_out, bus.B_ctp_out});
    end
    drive(3'd0, 3'd0, 2'b10, 2'b01, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.viol_count_b !== 8'd2) begin
      failures++; $display("FAIL rr_viol_b: got %0d expected 2", bus.viol_count_b);
    end
  endtask

  // rr_ptr is 0 here, so the first simultaneous request goes to A.
  task automatic test_hold();
    drive(3'd1, 3'd2, 2'b10, 2'b01, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.grant !== 2'b01) begin
      failures++; $display("FAIL hold_start: got %b expected 01", bus.grant);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (bus.grant !== 2'b01) begin
        failures++; $display("FAIL hold_a_cycle%0d: got %b expected 01", i, bus.grant);
      end
    end
    step();
    checks++;
    if ({bus.grant, bus.A_ctp_out, bus.B_ctp_out} !== 4'b10_01) begin
      failures++;
      $display("FAIL hold_switch_b: got %b expected 1001", {bus.grant, bus.A_ctp_out, bus.B_ctp_out});
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (bus.grant !== 2'b10) begin
        failures++; $display("FAIL hold_b_cycle%0d: got %b expected 10", i, bus.grant);
      end
    end
    step();
    checks++;
    if (bus.grant !== 2'b01) begin
      failures++; $display("FAIL hold_switch_back_a: got %b expected 01", bus.grant);
    end
    drive(3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
  endtask

  // rr_ptr is 1 after test_hold, so this grant goes to B.
  task automatic test_equal_edits();
    drive(3'd2, 3'd3, 2'b11, 2'b11, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.grant, bus.conflict, bus.A_ctp_out, bus.B_ctp_out} !== 5'b10_0_11) begin
      failures++;
      $display("FAIL equal_first: got %b expected 10011",
               {bus.grant, bus.conflict, bus.A_ctp_out, bus.B_ctp_out});
    end
    for (int i = 0; i < 6; i++) step();
    checks++;
    if ({bus.grant, bus.conflict} !== 3'b10_0) begin
      failures++; $display("FAIL equal_sticky: got %b expected 100", {bus.grant, bus.conflict});
    end
    drive(3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.viol_count_a, bus.viol_count_b} !== {8'd21, 8'd20}) begin
      failures++;
      $display("FAIL equal_viol_counts: got %0d/%0d expected 21/20",
               bus.viol_count_a, bus.viol_count_b);
    end
  endtask

  task automatic test_log();
    bus.log_ready = 1'b0;
    drive(3'd5, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    step();
    step();
    drive(3'd0, 3'd6, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.grant !== 2'b10) begin
      failures++; $display("FAIL log_second_grant: got %b expected 10", bus.grant);
    end
`ifdef AB_ARB_LOG_EN
    checks++;
    if ({bus.log_valid, bus.log_policy, bus.log_ref} !== 5'b1_0_101) begin
      failures++;
      $display("FAIL log_keep_old: got %b expected 10101", {bus.log_valid, bus.log_policy, bus.log_ref});
    end
`else
    checks++;
    if ({bus.log_valid, bus.log_policy, bus.log_ref} !== 5'b0) begin
      failures++;
      $display("FAIL log_tied_off: got %b expected 00000", {bus.log_valid, bus.log_policy, bus.log_ref});
    end
`endif
    bus.log_ready = 1'b1;
    drive(3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.log_valid !== 1'b0) begin
      failures++; $display("FAIL log_handshake_drop: got %b expected 0", bus.log_valid);
    end
    // Drain and reload in the same cycle.
    drive(3'd1, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    drive(3'd0, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
`ifdef AB_ARB_LOG_EN
    checks++;
    if ({bus.log_valid, bus.log_policy, bus.log_ref} !== 5'b1_1_010) begin
      failures++;
      $display("FAIL log_reload: got %b expected 11010", {bus.log_valid, bus.log_policy, bus.log_ref});
    end
`endif
    drive(3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.viol_count_a, bus.viol_count_b} !== {8'd25, 8'd22}) begin
      failures++;
      $display("FAIL log_viol_counts: got %0d/%0d expected 25/22",
               bus.viol_count_a, bus.viol_count_b);
    end
  endtask

  task automatic test_reset_mid_and_saturate();
    bus.log_ready = 1'b0;
    drive(3'd0, 3'd4, 2'b00, 2'b11, 1'b1, 1'b1);
    step();
    step();
    checks++;
    if (bus.grant !== 2'b10) begin
      failures++; $display("FAIL mid_pre_grant: got %b expected 10", bus.grant);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.grant, bus.conflict, bus.A_ctp_out, bus.B_ctp_out} !== 5'b0) begin
      failures++;
      $display("FAIL mid_reset_outs: got %b expected 00000",
               {bus.grant, bus.conflict, bus.A_ctp_out, bus.B_ctp_out});
    end
    checks++;
    if ({bus.viol_count_a, bus.viol_count_b} !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset_counts: got %0d/%0d expected 0/0", bus.viol_count_a, bus.viol_count_b);
    end
    checks++;
    if ({bus.log_valid, bus.log_policy, bus.log_ref} !== 5'b0) begin
      failures++;
      $display("FAIL mid_reset_log: got %b expected 00000", {bus.log_valid, bus.log_policy, bus.log_ref});
    end
    bus.log_ready = 1'b1;
    drive(3'd1, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 254; i++) step();
    checks++;
    if (bus.viol_count_a !== 8'd254) begin
      failures++; $display("FAIL sat_before: got %0d expected 254", bus.viol_count_a);
    end
    for (int i = 0; i < 46; i++) step();
    checks++;
    if ({bus.viol_count_a, bus.viol_count_b} !== {8'd255, 8'd0}) begin
      failures++;
      $display("FAIL sat_after_300: got %0d/%0d expected 255/0", bus.viol_count_a, bus.viol_count_b);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_a();
    test_round_robin();
    test_hold();
    test_equal_edits();
    test_log();
    test_reset_mid_and_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
